// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: fetch PC, word-addressed instruction memory and a prefetch FIFO
// with valid/ready output, flushing redirect and sticky misaligned-target fault.
// Optional IF_PERF_CNT_EN adds perf_fetched/perf_flushed counters.
module instr_fetch_queue #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned QDEPTH    = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  localparam int unsigned AW       = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_pc_plus_4,
  output logic          fault,
  output logic [31:0]   fault_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_flushed
`endif
);

  localparam int unsigned QW = $clog2(QDEPTH);
  localparam int unsigned CW = QW + 1;
  localparam logic [CW-1:0] QFull = CW'(QDEPTH);

  logic [31:0]   mem          [MEM_DEPTH];
  logic [31:0]   fifo_pc_q    [QDEPTH];
  logic [31:0]   fifo_instr_q [QDEPTH];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [QW-1:0] rd_ptr_q, rd_ptr_d;
  logic [QW-1:0] wr_ptr_q, wr_ptr_d;
  logic          fault_q, fault_d;
  logic [31:0]   fault_pc_q, fault_pc_d;
  logic [31:0]   fetch_instr;
  logic          pop, push;

  // Memory is never reset; a write is blocked only while reset is asserted.
  always_ff @(posedge clk) begin
    if (imem_we && !reset) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  assign fetch_instr = mem[fetch_pc_q[AW+1:2]];

  always_comb begin
    pop        = (count_q != '0) & out_ready & !redirect_valid;
    push       = !redirect_valid & !fault_q & ((count_q < QFull) | pop);
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
      if (redirect_pc[1:0] == 2'b00) begin
        fetch_pc_d = redirect_pc;
        fault_d    = 1'b0;
      end else begin
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
      end
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + QW'(1);
      end
      if (push) begin
        wr_ptr_d   = wr_ptr_q + QW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
      fifo_instr_q[wr_ptr_q] <= fetch_instr;
    end
  end

  always_comb begin
    out_valid     = (count_q != '0) & !redirect_valid;
    out_pc        = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
    out_instr     = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
    out_pc_plus_4 = out_valid ? fifo_pc_q[rd_ptr_q] + 32'd4 : '0;
    fault         = fault_q;
    fault_pc      = fault_pc_q;
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_flushed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (push) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (redirect_valid) begin
        perf_flushed_q <= perf_flushed_q + 32'(count_q);
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized plus directed bench for instr_fetch_queue against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int unsigned MD  = 64;
  localparam int unsigned QD  = 4;
  localparam int unsigned AW  = $clog2(MD);
  localparam logic [31:0] RPC = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset, redirect_valid, imem_we, out_ready;
  logic [31:0]   redirect_pc, imem_wdata;
  logic [AW-1:0] imem_waddr;
  logic          out_valid, fault;
  logic [31:0]   out_instr, out_pc, out_pc_plus_4, fault_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0]   perf_fetched, perf_flushed;
`endif

  instr_fetch_queue #(
    .MEM_DEPTH(MD),
    .QDEPTH   (QD),
    .RESET_PC (RPC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_plus_4 (out_pc_plus_4),
    .fault         (fault),
    .fault_pc      (fault_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_flushed  (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mem [MD];
  ent_t        m_q [$];
  logic [31:0] m_pc, m_fpc, m_fet, m_flu;
  logic        m_fault;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic we, input logic [AW-1:0] wa, input logic [31:0] wd);
    logic [31:0] fi;
    logic        do_pop, do_fetch;
    fi = m_mem[int'((m_pc / 4) % MD)];
    if (rst) begin
      m_q.delete();
      m_pc    = RPC;
      m_fault = 1'b0;
      m_fpc   = '0;
      m_fet   = '0;
      m_flu   = '0;
    end else begin
      if (rv) begin
        m_flu = m_flu + 32'(m_q.size());
        m_q.delete();
        if (rpc % 4 == 0) begin
          m_pc    = rpc;
          m_fault = 1'b0;
        end else begin
          m_fault = 1'b1;
          m_fpc   = rpc;
        end
      end else begin
        do_pop   = (m_q.size() > 0) && rdy;
        do_fetch = !m_fault && ((m_q.size() < QD) || do_pop);
        if (do_pop) void'(m_q.pop_front());
        if (do_fetch) begin
          m_q.push_back('{m_pc, fi});
          m_pc  = m_pc + 32'd4;
          m_fet = m_fet + 32'd1;
        end
      end
      if (we) m_mem[wa] = wd;
    end
  endtask

  // want >= 0: head must be valid with that PC; want == -2: head must be invalid.
  task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                      input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                      input int want);
    logic        ev;
    logic [31:0] epc, ei;
    @(negedge clk);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    imem_we        = we;
    imem_waddr     = wa;
    imem_wdata     = wd;
    #1;
    ev  = (m_q.size() != 0) && !rv;
    epc = ev ? m_q[0].pc : 32'h0;
    ei  = ev ? m_q[0].instr : 32'h0;
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_pc", out_pc, epc);
    check("out_instr", out_instr, ei);
    check("out_pc_plus_4", out_pc_plus_4, ev ? epc + 32'd4 : 32'h0);
    check("fault", 32'(fault), 32'(m_fault));
    check("fault_pc", fault_pc, m_fpc);
`ifdef IF_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fet);
    check("perf_flushed", perf_flushed, m_flu);
`endif
    if (want >= 0) begin
      check("dir_valid", 32'(out_valid), 32'h1);
      check("dir_pc", out_pc, 32'(want));
    end else if (want == -2) begin
      check("dir_idle", 32'(out_valid), 32'h0);
    end
    @(posedge clk);
    apply(rst, rv, rpc, rdy, we, wa, wd);
  endtask

  initial begin
    logic [31:0] rpc;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    imem_we        = 1'b0;
    imem_waddr     = '0;
    imem_wdata     = '0;
    @(posedge clk);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);

    // Program load while a misaligned redirect keeps fetch halted
    for (int i = 0; i < int'(MD); i++)
      step(1'b0, 1'b1, 32'h1, 1'b0, 1'b1, AW'(i), 32'h2001_0001 + 32'(i), -1);

    // 1) Reset then stream
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, -1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, -2);
    for (int k = 0; k < 4; k++)
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, 4 * k);

    // 2) Stall 10 cycles, then release; 5) keep draining a full queue for 16 cycles
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, -1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, -2);
    for (int k = 0; k < 9; k++)
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 0);
    for (int k = 0; k < 5; k++)
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, 4 * k);
    for (int k = 0; k < 16; k++)
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, 32'h14 + 4 * k);

    // 3) Redirect with three entries queued
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, -1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, -2);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, 0);
    step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, '0, 32'h0, -2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, -2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, 32'h40);

    // 4) Misaligned redirect faults, aligned one recovers
    step(1'b0, 1'b1, 32'h42, 1'b1, 1'b0, '0, 32'h0, -2);
    for (int k = 0; k < 20; k++)
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, -2);
    step(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, '0, 32'h0, -2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, -2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, 32'h80);

    // 6) Reset colliding with redirect and a memory write
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, -1);
    step(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, AW'(MD - 1), 32'hdead_beef, -1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, -2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, '0, 32'h0, int'(RPC));

    // Randomized traffic, including wrapping high targets and program rewrites
    for (int k = 0; k < 600; k++) begin
      rpc = 32'($urandom_range(0, 32'h3ff));
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0, rpc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           AW'($urandom_range(0, MD - 1)), $urandom, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
